// File: rtl/spi_byte_sequencer.sv
// Feeds the 8-bit SPI shift stage one byte at a time from a TX FIFO and
// collects each received byte into an RX FIFO, with a per-edge spi_ssn timeout.
module spi_byte_sequencer #(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       spi_load,
    output logic [7:0] spi_datain,
    output logic       spi_unload,
    input  logic [7:0] spi_dataout,
    input  logic       spi_ssn,
    output logic       busy,
    output logic       timeout_err,
    input  logic       clear_err
);

    localparam int TXAW = $clog2(TX_DEPTH);
    localparam int RXAW = $clog2(RX_DEPTH);
    localparam logic [TXAW:0] TX_FULL   = (TXAW+1)'(TX_DEPTH);
    localparam logic [RXAW:0] RX_FULL   = (RXAW+1)'(RX_DEPTH);
    localparam logic [3:0]    WAIT_LAST = 4'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_LOW, WAIT_HIGH, UNLOAD} state_t;

    state_t          state_q, state_d;
    logic [TXAW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [TXAW:0]   tx_cnt_q, tx_cnt_d;
    logic [RXAW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [RXAW:0]   rx_cnt_q, rx_cnt_d;
    logic [7:0]      tx_mem_q [TX_DEPTH];
    logic [7:0]      rx_mem_q [RX_DEPTH];
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic            spi_load_q, spi_load_d;
    logic            spi_unload_q, spi_unload_d;
    logic [7:0]      spi_datain_q, spi_datain_d;
    logic            timeout_err_q, timeout_err_d;
    logic            err_set;
    logic            tx_push, tx_pop, rx_push, rx_pop;

    assign tx_ready    = (tx_cnt_q != TX_FULL);
    assign rx_valid    = (rx_cnt_q != '0);
    assign rx_data     = rx_valid ? rx_mem_q[rx_rd_q] : 8'h00;
    assign tx_push     = tx_valid && tx_ready;
    assign tx_pop      = (state_q == LOAD);
    assign rx_push     = (state_q == UNLOAD);
    assign rx_pop      = rx_valid && rx_ready;
    assign spi_load    = spi_load_q;
    assign spi_unload  = spi_unload_q;
    assign spi_datain  = spi_datain_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (tx_push) begin
            tx_wr_d  = tx_wr_q + 1'b1;
            tx_cnt_d = tx_cnt_d + 1'b1;
        end
        if (tx_pop) begin
            tx_rd_d  = tx_rd_q + 1'b1;
            tx_cnt_d = tx_cnt_d - 1'b1;
        end
        if (rx_push) begin
            rx_wr_d  = rx_wr_q + 1'b1;
            rx_cnt_d = rx_cnt_d + 1'b1;
        end
        if (rx_pop) begin
            rx_rd_d  = rx_rd_q + 1'b1;
            rx_cnt_d = rx_cnt_d - 1'b1;
        end
    end

    // Only one byte is ever in flight, so checking RX space before LOAD
    // guarantees the capture slot.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = '0;
        err_set      = 1'b0;
        spi_load_d   = 1'b0;
        spi_unload_d = 1'b0;
        spi_datain_d = spi_datain_q;
        case (state_q)
            IDLE: begin
                if (tx_cnt_q != '0 && rx_cnt_q != RX_FULL) state_d = LOAD;
            end
            LOAD: state_d = WAIT_LOW;
            WAIT_LOW: begin
                if (!spi_ssn) begin
                    state_d = WAIT_HIGH;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (spi_ssn) begin
                    state_d = UNLOAD;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            UNLOAD: begin
                if (tx_cnt_q != '0 && rx_cnt_d != RX_FULL) state_d = LOAD;
                else state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Strobes are decoded from the next state so they leave a flop.
        if (state_d == LOAD) begin
            spi_load_d   = 1'b1;
            spi_datain_d = tx_mem_q[tx_rd_q];
        end
        if (state_d == UNLOAD) spi_unload_d = 1'b1;
        if (err_set) timeout_err_d = 1'b1;
        else if (clear_err) timeout_err_d = 1'b0;
        else timeout_err_d = timeout_err_q;
    end

    always_ff @(posedge clock_in) begin
        if (!reset) begin
            state_q       <= IDLE;
            tx_wr_q       <= '0;
            tx_rd_q       <= '0;
            tx_cnt_q      <= '0;
            rx_wr_q       <= '0;
            rx_rd_q       <= '0;
            rx_cnt_q      <= '0;
            wait_cnt_q    <= '0;
            spi_load_q    <= 1'b0;
            spi_unload_q  <= 1'b0;
            spi_datain_q  <= 8'h00;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_wr_q       <= tx_wr_d;
            tx_rd_q       <= tx_rd_d;
            tx_cnt_q      <= tx_cnt_d;
            rx_wr_q       <= rx_wr_d;
            rx_rd_q       <= rx_rd_d;
            rx_cnt_q      <= rx_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            spi_load_q    <= spi_load_d;
            spi_unload_q  <= spi_unload_d;
            spi_datain_q  <= spi_datain_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_ff @(posedge clock_in) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= tx_data;
        if (rx_push) rx_mem_q[rx_wr_q] <= spi_dataout;
    end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Bench for spi_byte_sequencer: behavioural shift-stage model, load/RX
// scoreboards, a vector table and directed corner-case sequences.
module tb_spi_byte_sequencer;

    localparam int TIMEOUT = 15;

    logic       clock_in    = 1'b0;
    logic       reset       = 1'b0;
    logic [7:0] tx_data     = 8'h00;
    logic       tx_valid    = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready    = 1'b0;
    logic       spi_load;
    logic [7:0] spi_datain;
    logic       spi_unload;
    logic [7:0] spi_dataout = 8'h00;
    logic       spi_ssn     = 1'b1;
    logic       busy;
    logic       timeout_err;
    logic       clear_err   = 1'b0;

    spi_byte_sequencer #(.TX_DEPTH(4), .RX_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clock_in(clock_in), .reset(reset),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .spi_load(spi_load), .spi_datain(spi_datain), .spi_unload(spi_unload),
        .spi_dataout(spi_dataout), .spi_ssn(spi_ssn),
        .busy(busy), .timeout_err(timeout_err), .clear_err(clear_err)
    );

    always #5 clock_in = ~clock_in;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endfunction

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    // Shift-stage model: ssn low for 8 cycles after each load, returns byte ^ 0x99.
    int model_mode = 0;
    int ssn_cnt    = 0;
    always @(posedge clock_in) begin
        if (model_mode != 0) begin
            spi_ssn <= 1'b1;
            ssn_cnt <= 0;
        end else if (ssn_cnt != 0) begin
            ssn_cnt <= ssn_cnt - 1;
            if (ssn_cnt == 1) spi_ssn <= 1'b1;
        end else if (spi_load) begin
            spi_ssn     <= 1'b0;
            ssn_cnt     <= 8;
            spi_dataout <= spi_datain ^ 8'h99;
        end
    end

    int         cyc = 0;
    logic [7:0] load_q[$];
    logic [7:0] rx_q[$];
    int         load_cyc[$];
    int         n_load   = 0;
    int         n_unload = 0;
    bit         saw_full = 1'b0;

    always @(posedge clock_in) cyc <= cyc + 1;

    always @(negedge clock_in) begin
        if (reset) begin
            if (spi_load) begin
                n_load++;
                load_cyc.push_back(cyc);
                if (load_q.size() == 0) fail_now("load_unexpected", spi_datain);
                else check("load_order", spi_datain, load_q.pop_front());
            end
            if (spi_unload) n_unload++;
            if (!tx_ready) saw_full = 1'b1;
            if (rx_valid && rx_ready) begin
                if (rx_q.size() == 0) fail_now("rx_unexpected", rx_data);
                else check("rx_order", rx_data, rx_q.pop_front());
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit exp_load, input bit exp_rx, input logic [7:0] rx_val);
        int n;
        n = 0;
        while (!tx_ready && n < 300) begin
            tick();
            n++;
        end
        check("push_ready", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        if (exp_load) load_q.push_back(b);
        if (exp_rx) rx_q.push_back(rx_val);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx_valid(input int bound);
        for (int i = 0; i < bound && !rx_valid; i++) tick();
    endtask

    task automatic wait_spi_load(input int bound);
        for (int i = 0; i < bound && !spi_load; i++) tick();
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && (rx_q.size() != 0 || load_q.size() != 0 || busy); i++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_ready"}, tx_ready, 1);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_spi_load"}, spi_load, 0);
        check({tag, "_spi_unload"}, spi_unload, 0);
        check({tag, "_spi_datain"}, spi_datain, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   base_load;
        int   base_unload;
        int   first_err;

        vecs[0] = '{8'h00, 8'h99};
        vecs[1] = '{8'hFF, 8'h66};
        vecs[2] = '{8'h5A, 8'hC3};
        vecs[3] = '{8'h80, 8'h19};
        vecs[4] = '{8'h01, 8'h98};
        vecs[5] = '{8'h3C, 8'hA5};

        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Single byte
        push_byte(8'hA5, 1, 1, 8'h3C);
        wait_rx_valid(60);
        check("single_rx_valid", rx_valid, 1);
        check("single_rx_data", rx_data, 8'h3C);
        check("single_busy", busy, 0);
        check("single_loads", n_load, 1);
        check("single_unloads", n_unload, 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("single_rx_empty", rx_valid, 0);

        // Vector table
        for (int v = 0; v < 6; v++) begin
            push_byte(vecs[v].tx, 1, 1, vecs[v].rx);
            wait_rx_valid(60);
            check($sformatf("vec%0d_rx_valid", v), rx_valid, 1);
            check($sformatf("vec%0d_rx_data", v), rx_data, vecs[v].rx);
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end

        // Back-to-back
        load_cyc.delete();
        rx_ready = 1'b1;
        push_byte(8'h11, 1, 1, 8'h88);
        push_byte(8'h22, 1, 1, 8'hBB);
        wait_drain(120);
        check("b2b_drained", rx_q.size(), 0);
        check("b2b_loads", load_cyc.size(), 2);
        if (load_cyc.size() >= 2) check("b2b_spacing", load_cyc[1] - load_cyc[0], 11);
        rx_ready = 1'b0;

        // TX full with stalled shift stage
        model_mode = 1;
        tick();
        base_load = n_load;
        saw_full  = 1'b0;
        for (int b = 1; b <= 5; b++) push_byte(8'(b), 1, 0, 8'h00);
        tick();
        check("full_tx_ready_dropped", saw_full, 1);
        wait_drain(400);
        check("full_loads", n_load - base_load, 5);
        check("full_load_q_empty", load_q.size(), 0);
        check("full_rx_none", rx_valid, 0);
        check("full_err_set", timeout_err, 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("full_err_cleared", timeout_err, 0);
        model_mode = 0;
        tick();

        // Timeout timing
        model_mode = 1;
        tick();
        push_byte(8'h5A, 1, 0, 8'h00);
        wait_spi_load(20);
        check("to_load_seen", spi_load, 1);
        tick();
        first_err = 0;
        for (int k = 1; k <= TIMEOUT + 2; k++) begin
            tick();
            if (timeout_err && first_err == 0) first_err = k;
        end
        check("to_cycles", first_err, TIMEOUT);
        check("to_no_rx", rx_valid, 0);
        check("to_idle", busy, 0);
        model_mode = 0;
        tick();
        rx_ready = 1'b1;
        push_byte(8'h77, 1, 1, 8'hEE);
        wait_drain(60);
        check("to_next_rx", rx_q.size(), 0);
        check("to_err_sticky", timeout_err, 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("to_err_cleared", timeout_err, 0);
        rx_ready = 1'b0;

        // RX backpressure
        base_load = n_load;
        for (int b = 0; b < 6; b++) push_byte(8'h31 + 8'(b), 1, 1, (8'h31 + 8'(b)) ^ 8'h99);
        for (int i = 0; i < 200 && (n_load - base_load < 4 || busy); i++) tick();
        repeat (20) tick();
        check("bp_loads_stalled", n_load - base_load, 4);
        check("bp_idle", busy, 0);
        check("bp_rx_valid", rx_valid, 1);
        check("bp_rx_head", rx_data, 8'hA8);
        check("bp_tx_ready", tx_ready, 1);
        check("bp_tx_holding", load_q.size(), 2);
        rx_ready = 1'b1;
        wait_drain(200);
        check("bp_loads_total", n_load - base_load, 6);
        check("bp_rx_drained", rx_q.size(), 0);
        rx_ready = 1'b0;

        // Mid-transfer reset
        push_byte(8'h42, 1, 0, 8'h00);
        push_byte(8'h43, 0, 0, 8'h00);
        wait_spi_load(20);
        check("mr_load_seen", spi_load, 1);
        tick();
        tick();
        check("mr_busy_before", busy, 1);
        reset = 1'b0;
        tick();
        check_reset_outputs("mr");
        reset = 1'b1;
        base_load   = n_load;
        base_unload = n_unload;
        repeat (25) tick();
        check("mr_no_unload", n_unload - base_unload, 0);
        check("mr_no_load", n_load - base_load, 0);
        check("mr_rx_empty", rx_valid, 0);
        check("mr_idle", busy, 0);

        check("end_load_q", load_q.size(), 0);
        check("end_rx_q", rx_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
